// File: rtl/wb_arbiter_if.sv
// Register-file write-back bus between the pipeline/LLU side and wb_arbiter.
// master drives the pipeline and LLU requests; slave is the arbiter.
interface wb_arbiter_if;
  logic        WB_RegWrite;
  logic [4:0]  WB_rd_addr;
  logic [31:0] WB_rd_data;
  logic        llu_valid;
  logic [4:0]  llu_rd_addr;
  logic [31:0] llu_rd_data;
  logic        llu_ready;
  logic        stall_req;
  logic        llu_pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output WB_RegWrite, WB_rd_addr, WB_rd_data,
    output llu_valid, llu_rd_addr, llu_rd_data,
    input  llu_ready, stall_req, llu_pending,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  WB_RegWrite, WB_rd_addr, WB_rd_data,
    input  llu_valid, llu_rd_addr, llu_rd_data,
    output llu_ready, stall_req, llu_pending,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_arbiter.sv
// Shares one register-file write port between pipeline write-back and a 2-entry LLU result FIFO.
// Define WB_ARB_STARVE_EN to add the anti-starvation FORCE cycle (stall_req) after STARVE_MAX WB grants.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
    $error("wb_arbiter: STARVE_MAX must be within 1..7");
  end

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;
  logic          r_rf_we;
  logic [AW-1:0] r_rf_waddr;
  logic [DW-1:0] r_rf_wdata;

  logic w_llu_ready;
  logic w_wb_req;
  logic w_push;
  logic w_pop;
  logic w_sel_wb;

  assign w_llu_ready = (r_count < 2'd2) && rst;
  assign w_wb_req    = bus.WB_RegWrite && (bus.WB_rd_addr != '0);
  // Results for r0 are accepted but never stored.
  assign w_push      = bus.llu_valid && w_llu_ready && (bus.llu_rd_addr != '0);

`ifdef WB_ARB_STARVE_EN
  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_starve_cnt;
  logic [2:0] w_starve_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  // FORCE overrides the pipeline for one cycle to drain the FIFO head.
  always_comb begin
    w_state_next  = NORMAL;
    w_starve_next = r_starve_cnt;
    w_sel_wb      = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      FORCE: begin
        w_pop = (r_count != '0);
      end
      default: begin
        if (w_wb_req) begin
          w_sel_wb = 1'b1;
        end else begin
          w_pop = (r_count != '0);
        end
      end
    endcase
    if (w_pop || (r_count == '0)) begin
      w_starve_next = '0;
    end else if (w_sel_wb) begin
      w_starve_next = r_starve_cnt + 3'd1;
    end
    if (w_starve_next == STARVE_LIM) begin
      w_state_next = FORCE;
    end
  end

  assign bus.stall_req = (r_state == FORCE);
`else
  always_comb begin
    w_sel_wb = w_wb_req;
    w_pop    = !w_wb_req && (r_count != '0);
  end

  assign bus.stall_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= bus.llu_rd_addr;
      r_mem_data[r_wptr] <= bus.llu_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Registered write port; address/data hold when nothing is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_sel_wb) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= bus.WB_rd_addr;
      r_rf_wdata <= bus.WB_rd_data;
    end else if (w_pop) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= r_mem_addr[r_rptr];
      r_rf_wdata <= r_mem_data[r_rptr];
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign bus.llu_ready   = w_llu_ready;
  assign bus.llu_pending = (r_count != '0);
  assign bus.rf_we       = r_rf_we;
  assign bus.rf_waddr    = r_rf_waddr;
  assign bus.rf_wdata    = r_rf_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus random traffic against a queue-based model.
// Follows WB_ARB_STARVE_EN the same way the design does.
module tb_wb_arbiter;

  localparam int unsigned TB_STARVE = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } entry_t;

  logic clk;
  logic rst;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_MAX(TB_STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp;
  int          n_fail;
  entry_t      q[$];
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  bit          m_force;
  int          m_streak;
  logic [40:0] w_obs;

  assign w_obs = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.llu_pending, bus.llu_ready, bus.stall_req};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [40:0] exp_vec();
    return {exp_we, exp_waddr, exp_wdata, (q.size() != 0), ((q.size() < 2) && (rst == 1'b1)), m_force};
  endfunction

  task automatic set_idle();
    bus.WB_RegWrite = 1'b0;
    bus.WB_rd_addr  = '0;
    bus.WB_rd_data  = '0;
    bus.llu_valid   = 1'b0;
    bus.llu_rd_addr = '0;
    bus.llu_rd_data = '0;
  endtask

  task automatic model_reset();
    q.delete();
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    m_force   = 1'b0;
    m_streak  = 0;
  endtask

  // Advance one clock and update the reference model from the inputs held across that edge.
  task automatic clock_cycle();
    bit          wb_req;
    bit          push;
    bit          take_head;
    bit          sel_wb;
    int          pre_size;
    entry_t      e;
    entry_t      head;
    logic [4:0]  wa;
    logic [31:0] wd;
    pre_size  = q.size();
    wb_req    = bus.WB_RegWrite && (bus.WB_rd_addr != 0);
    push      = bus.llu_valid && (pre_size < 2) && (bus.llu_rd_addr != 0);
    e.a       = bus.llu_rd_addr;
    e.d       = bus.llu_rd_data;
    wa        = bus.WB_rd_addr;
    wd        = bus.WB_rd_data;
    sel_wb    = 1'b0;
    take_head = 1'b0;
`ifdef WB_ARB_STARVE_EN
    if (m_force) take_head = (pre_size > 0);
    else if (wb_req) sel_wb = 1'b1;
    else take_head = (pre_size > 0);
`else
    sel_wb    = wb_req;
    take_head = !wb_req && (pre_size > 0);
`endif
    @(posedge clk);
    #1;
    if (sel_wb) begin
      exp_we = 1'b1; exp_waddr = wa; exp_wdata = wd;
    end else if (take_head) begin
      head = q.pop_front();
      exp_we = 1'b1; exp_waddr = head.a; exp_wdata = head.d;
    end else begin
      exp_we = 1'b0;
    end
    if (push) q.push_back(e);
`ifdef WB_ARB_STARVE_EN
    if (take_head || pre_size == 0) m_streak = 0;
    else if (sel_wb) m_streak++;
    m_force = (m_streak == TB_STARVE);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    model_reset();
    #1;
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== 38'd0) begin
      n_fail++; $display("FAIL reset_rf: got %h expected 0", {bus.rf_we, bus.rf_waddr, bus.rf_wdata});
    end
    n_cmp++;
    if ({bus.llu_pending, bus.llu_ready, bus.stall_req} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.llu_pending, bus.llu_ready, bus.stall_req});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.llu_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 1", bus.llu_ready);
    end
  endtask

  task automatic test_wb_write();
    bus.WB_RegWrite = 1'b1; bus.WB_rd_addr = 5'd5; bus.WB_rd_data = 32'hDEADBEEF;
    clock_cycle();
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wb_write: got %h expected %h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd5, 32'hDEADBEEF});
    end
    set_idle();
    clock_cycle();
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wb_hold: got %h expected %h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b0, 5'd5, 32'hDEADBEEF});
    end
  endtask

  task automatic test_addr_zero();
    bus.WB_RegWrite = 1'b1; bus.WB_rd_addr = 5'd0; bus.WB_rd_data = 32'h55;
    clock_cycle();
    n_cmp++;
    if (bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL wb_addr0_we: got %b expected 0", bus.rf_we);
    end
    set_idle();
    bus.llu_valid = 1'b1; bus.llu_rd_addr = 5'd0; bus.llu_rd_data = 32'h77;
    clock_cycle();
    n_cmp++;
    if (bus.llu_pending !== 1'b0) begin
      n_fail++; $display("FAIL llu_addr0_pending: got %b expected 0", bus.llu_pending);
    end
    set_idle();
    clock_cycle();
    n_cmp++;
    if ({bus.rf_we, bus.llu_pending} !== 2'b00) begin
      n_fail++; $display("FAIL llu_addr0_drain: got %b expected 00", {bus.rf_we, bus.llu_pending});
    end
  endtask

  task automatic test_llu_latency();
    bus.llu_valid = 1'b1; bus.llu_rd_addr = 5'd7; bus.llu_rd_data = 32'h1234;
    clock_cycle();
    set_idle();
    n_cmp++;
    if ({bus.rf_we, bus.llu_pending} !== 2'b01) begin
      n_fail++; $display("FAIL llu_t1: got we/pend %b expected 01", {bus.rf_we, bus.llu_pending});
    end
    clock_cycle();
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.llu_pending} !== {1'b1, 5'd7, 32'h1234, 1'b0}) begin
      n_fail++; $display("FAIL llu_t2: got %h expected %h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.llu_pending}, {1'b1, 5'd7, 32'h1234, 1'b0});
    end
  endtask

  task automatic test_backpressure();
    bus.WB_RegWrite = 1'b1; bus.WB_rd_addr = 5'd10; bus.WB_rd_data = 32'hA0;
    bus.llu_valid = 1'b1; bus.llu_rd_addr = 5'd3; bus.llu_rd_data = 32'hA;
    clock_cycle();
    bus.WB_rd_addr = 5'd11; bus.llu_rd_addr = 5'd4; bus.llu_rd_data = 32'hB;
    clock_cycle();
    bus.llu_rd_addr = 5'd6; bus.llu_rd_data = 32'hC;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus.llu_ready, bus.llu_pending} !== 2'b01) begin
        n_fail++; $display("FAIL bp_full[%0d]: got ready/pend %b expected 01", i, {bus.llu_ready, bus.llu_pending});
      end
      bus.WB_rd_addr = 5'(12 + i);
      clock_cycle();
      n_cmp++;
      if (w_obs !== exp_vec()) begin
        n_fail++; $display("FAIL bp_model[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
    end
    bus.WB_RegWrite = 1'b0;
    clock_cycle();
    n_cmp++;
    if ({bus.rf_waddr, bus.llu_ready, bus.llu_pending} !== {5'd3, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL bp_pop1: got %h expected %h", {bus.rf_waddr, bus.llu_ready, bus.llu_pending}, {5'd3, 1'b1, 1'b1});
    end
    clock_cycle();
    bus.llu_valid = 1'b0;
    n_cmp++;
    if ({bus.rf_waddr, bus.llu_pending} !== {5'd4, 1'b1}) begin
      n_fail++; $display("FAIL bp_accept3: got %h expected %h", {bus.rf_waddr, bus.llu_pending}, {5'd4, 1'b1});
    end
    clock_cycle();
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.llu_pending} !== {1'b1, 5'd6, 32'hC, 1'b0}) begin
      n_fail++; $display("FAIL bp_pop3: got %h expected %h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.llu_pending}, {1'b1, 5'd6, 32'hC, 1'b0});
    end
  endtask

`ifdef WB_ARB_STARVE_EN
  task automatic test_starve();
    set_idle();
    repeat (3) clock_cycle();
    bus.WB_RegWrite = 1'b1; bus.WB_rd_addr = 5'd1; bus.WB_rd_data = 32'd100;
    bus.llu_valid = 1'b1; bus.llu_rd_addr = 5'd9; bus.llu_rd_data = 32'h99;
    clock_cycle();
    bus.llu_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      bus.WB_rd_addr = 5'(k); bus.WB_rd_data = 32'(100 + k);
      clock_cycle();
      n_cmp++;
      if ({bus.rf_waddr, bus.stall_req} !== {5'(k), (k == 5)}) begin
        n_fail++; $display("FAIL starve_grant[%0d]: got %h expected %h", k, {bus.rf_waddr, bus.stall_req}, {5'(k), (k == 5)});
      end
    end
    bus.WB_rd_addr = 5'd6; bus.WB_rd_data = 32'd106;
    clock_cycle();
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_req} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
      n_fail++; $display("FAIL starve_force: got %h expected %h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_req}, {1'b1, 5'd9, 32'h99, 1'b0});
    end
    clock_cycle();
    n_cmp++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd6, 32'd106}) begin
      n_fail++; $display("FAIL starve_held_wb: got %h expected %h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd6, 32'd106});
    end
    set_idle();
  endtask
`endif

  task automatic test_reset_midop();
    set_idle();
    repeat (2) clock_cycle();
    bus.WB_RegWrite = 1'b1; bus.WB_rd_addr = 5'd20; bus.WB_rd_data = 32'h20;
    bus.llu_valid = 1'b1; bus.llu_rd_addr = 5'd11; bus.llu_rd_data = 32'h11;
    clock_cycle();
    bus.llu_rd_addr = 5'd12; bus.llu_rd_data = 32'h12;
    clock_cycle();
    n_cmp++;
    if ({bus.rf_we, bus.llu_pending, bus.llu_ready} !== 3'b110) begin
      n_fail++; $display("FAIL midrst_pre: got %b expected 110", {bus.rf_we, bus.llu_pending, bus.llu_ready});
    end
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rf_we, bus.llu_pending, bus.stall_req, bus.llu_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_async: got %b expected 0000", {bus.rf_we, bus.llu_pending, bus.stall_req, bus.llu_ready});
    end
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clock_cycle();
      n_cmp++;
      if (w_obs !== exp_vec() || bus.rf_we !== 1'b0) begin
        n_fail++; $display("FAIL midrst_after[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      // The pipeline freezes its WB request while stalled.
      if (!m_force) begin
        bus.WB_RegWrite = ($urandom_range(0, 9) < 6);
        bus.WB_rd_addr  = 5'($urandom_range(0, 31));
        bus.WB_rd_data  = $urandom;
      end
      bus.llu_valid   = ($urandom_range(0, 2) == 0);
      bus.llu_rd_addr = 5'($urandom_range(0, 31));
      bus.llu_rd_data = $urandom;
      clock_cycle();
      n_cmp++;
      if (w_obs !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, w_obs, exp_vec());
      end
    end
    set_idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_wb_write();
    test_addr_zero();
    test_llu_latency();
    test_backpressure();
`ifdef WB_ARB_STARVE_EN
    test_starve();
`endif
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
